exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_unit.sv | 211 +++++++++++++++++++++
 tb/tb_exec_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// exec_unit: small multi-cycle ALU feeding a register-file write port and a
// carry-register write port. Single-cycle ADD/SUB/logic ops, bit-serial
// shifts and an optional shift-add multiplier.
// Build option: define ALU_MUL_EN to include the multiplier; without it op 7
// is accepted as a no-op that produces a WB cycle with both strobes low.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for an operation, in_ready high
// ST_CALC | iterating a shift or multiply, cnt_q counts remaining steps
// ST_WB   | one-cycle write-back, may accept the next operation
module exec_unit #(
   parameter int reg_width = 8,
   parameter int num_regs  = 12
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [2:0]                  op,
   input  logic [reg_width-1:0]        rs_val,
   input  logic [reg_width-1:0]        rt_val,
   input  logic [$clog2(num_regs)-1:0] rd_addr,
   output logic [$clog2(num_regs)-1:0] wb_rd_addr,
   output logic [reg_width-1:0]        wb_rd_in,
   output logic                        wb_reg_write,
   output logic [reg_width-1:0]        wb_car_in,
   output logic                        wb_car_write,
   output logic                        busy
);

   localparam int addr_w = $clog2(num_regs);
   localparam int cnt_w  = $clog2(reg_width + 8);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   state_t               state;
   logic [2:0]           op_q;
   logic [reg_width-1:0] a_q;
   logic [addr_w-1:0]    rd_q;
   logic [cnt_w-1:0]     cnt_q;

   logic [reg_width:0]   sum_ext;
   logic [reg_width:0]   diff_ext;
   logic [2:0]           shamt;
   logic [reg_width-1:0] acc_res;
   logic [reg_width-1:0] acc_car;
   logic                 acc_carw;
   logic                 acc_calc;
   logic                 acc_nop;
   logic [cnt_w-1:0]     acc_cnt;
   logic [reg_width-1:0] shift_next;

`ifdef ALU_MUL_EN
   // a_q holds the running high half, mlo_q the low half / remaining multiplier
   logic [reg_width-1:0] mcand_q;
   logic [reg_width-1:0] mlo_q;
   logic [reg_width:0]   mul_sum;
   logic [reg_width-1:0] mhi_next;
   logic [reg_width-1:0] mlo_next;

   // one shift-add step: add multiplicand if multiplier LSB set, shift product right
   always_comb begin
      mul_sum  = {1'b0, a_q} + (mlo_q[0] ? {1'b0, mcand_q} : '0);
      mhi_next = mul_sum[reg_width:1];
      mlo_next = {mul_sum[0], mlo_q[reg_width-1:1]};
   end
`endif

   // decode of the offered operation: single-cycle result or iteration setup
   always_comb begin
      sum_ext  = {1'b0, rs_val} + {1'b0, rt_val};
      diff_ext = {1'b0, rs_val} - {1'b0, rt_val};
      shamt    = rt_val[2:0];
      acc_res  = '0;
      acc_car  = '0;
      acc_carw = 1'b0;
      acc_calc = 1'b0;
      acc_nop  = 1'b0;
      acc_cnt  = cnt_w'(shamt);
      case (op)
         OP_ADD: begin
            acc_res  = sum_ext[reg_width-1:0];
            acc_car  = reg_width'(sum_ext[reg_width]);
            acc_carw = 1'b1;
         end
         OP_SUB: begin
            // the borrow out of the extended subtraction is exactly rs < rt
            acc_res  = diff_ext[reg_width-1:0];
            acc_car  = reg_width'(diff_ext[reg_width]);
            acc_carw = 1'b1;
         end
         OP_AND: acc_res = rs_val & rt_val;
         OP_OR:  acc_res = rs_val | rt_val;
         OP_XOR: acc_res = rs_val ^ rt_val;
         OP_SHL, OP_SHR: begin
            // a zero shift amount completes like any single-cycle op
            acc_res  = rs_val;
            acc_calc = (shamt != 3'd0);
         end
         default: begin
`ifdef ALU_MUL_EN
            acc_calc = 1'b1;
            acc_cnt  = cnt_w'(reg_width);
`else
            acc_nop  = 1'b1;
`endif
         end
      endcase
   end

   // one-bit logical shift step for the iterating shift
   always_comb begin
      shift_next = (op_q == OP_SHL) ? (a_q << 1) : (a_q >> 1);
   end

   // FSM, operand latches and registered write-back outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         op_q         <= '0;
         a_q          <= '0;
         rd_q         <= '0;
         cnt_q        <= '0;
         wb_rd_addr   <= '0;
         wb_rd_in     <= '0;
         wb_reg_write <= 1'b0;
         wb_car_in    <= '0;
         wb_car_write <= 1'b0;
`ifdef ALU_MUL_EN
         mcand_q      <= '0;
         mlo_q        <= '0;
`endif
      end else begin
         wb_reg_write <= 1'b0;
         wb_car_write <= 1'b0;
         case (state)
            ST_CALC: begin
               cnt_q <= cnt_q - 1'b1;
               a_q   <= shift_next;
`ifdef ALU_MUL_EN
               if (op_q == OP_MUL) begin
                  a_q   <= mhi_next;
                  mlo_q <= mlo_next;
               end
`endif
               if (cnt_q == cnt_w'(1)) begin
                  state        <= ST_WB;
                  wb_rd_addr   <= rd_q;
                  wb_reg_write <= (rd_q != '0);
                  wb_rd_in     <= shift_next;
`ifdef ALU_MUL_EN
                  if (op_q == OP_MUL) begin
                     wb_rd_in     <= mlo_next;
                     wb_car_in    <= mhi_next;
                     wb_car_write <= 1'b1;
                  end
`endif
               end
            end
            default: begin
               // IDLE and WB both accept; an unused encoding behaves as IDLE
               if (in_valid) begin
                  op_q  <= op;
                  a_q   <= rs_val;
                  rd_q  <= rd_addr;
                  cnt_q <= acc_cnt;
`ifdef ALU_MUL_EN
                  mcand_q <= rs_val;
                  mlo_q   <= rt_val;
                  if (op == OP_MUL) a_q <= '0;
`endif
                  if (acc_calc) begin
                     state <= ST_CALC;
                  end else begin
                     state <= ST_WB;
                     if (!acc_nop) begin
                        wb_rd_addr   <= rd_addr;
                        wb_rd_in     <= acc_res;
                        wb_reg_write <= (rd_addr != '0);
                        if (acc_carw) begin
                           wb_car_in    <= acc_car;
                           wb_car_write <= 1'b1;
                        end
                     end
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign in_ready = (state != ST_CALC);
   assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed and random operations against an arithmetic
// reference model of the write-back results and latencies.
module tb_exec_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] op;
   logic [7:0] rs_val;
   logic [7:0] rt_val;
   logic [3:0] rd_addr;
   logic [3:0] wb_rd_addr;
   logic [7:0] wb_rd_in;
   logic       wb_reg_write;
   logic [7:0] wb_car_in;
   logic       wb_car_write;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int exp_addr = 0;
   int exp_rd = 0;
   int exp_car = 0;

   always #5 clk = ~clk;

   exec_unit #(.reg_width(8), .num_regs(12)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .op           (op),
      .rs_val       (rs_val),
      .rt_val       (rt_val),
      .rd_addr      (rd_addr),
      .wb_rd_addr   (wb_rd_addr),
      .wb_rd_in     (wb_rd_in),
      .wb_reg_write (wb_reg_write),
      .wb_car_in    (wb_car_in),
      .wb_car_write (wb_car_write),
      .busy         (busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // result, carry and latency straight from the operation definitions
   function automatic void model(input int o, input int a, input int b,
                                 output int lat, output int res, output int car,
                                 output bit carw, output bit nop);
      int n;
      n    = b % 8;
      lat  = 1;
      res  = 0;
      car  = 0;
      carw = 1'b0;
      nop  = 1'b0;
      case (o)
         0: begin res = (a + b) % 256; car = (a + b) / 256; carw = 1'b1; end
         1: begin res = (a - b + 256) % 256; car = (a < b) ? 1 : 0; carw = 1'b1; end
         2: res = a & b;
         3: res = a | b;
         4: res = a ^ b;
         5: begin res = (a * (1 << n)) % 256; lat = n + 1; end
         6: begin res = a / (1 << n); lat = n + 1; end
         default: begin
`ifdef ALU_MUL_EN
            res = (a * b) % 256; car = (a * b) / 256; carw = 1'b1; lat = 9;
`else
            nop = 1'b1;
`endif
         end
      endcase
   endfunction

   task automatic chk_idle_hold(input string tag);
      chk({tag, " idle busy"}, 32'(busy), 0);
      chk({tag, " idle ready"}, 32'(in_ready), 1);
      chk({tag, " idle strobes"}, 32'({wb_reg_write, wb_car_write}), 0);
      chk({tag, " hold addr"}, 32'(wb_rd_addr), exp_addr);
      chk({tag, " hold rd"}, 32'(wb_rd_in), exp_rd);
      chk({tag, " hold car"}, 32'(wb_car_in), exp_car);
   endtask

   task automatic run_op(input int o, input int a, input int b, input int rd,
                         input bit go_idle, input string tag);
      int lat, res, car;
      bit carw, nop;
      model(o, a, b, lat, res, car, carw, nop);
      in_valid = 1'b1;
      op       = o[2:0];
      rs_val   = a[7:0];
      rt_val   = b[7:0];
      rd_addr  = rd[3:0];
      chk({tag, " ready at offer"}, 32'(in_ready), 1);
      tick;
      in_valid = 1'b0;
      op       = 3'($urandom);
      rs_val   = 8'($urandom);
      rt_val   = 8'($urandom);
      rd_addr  = 4'($urandom_range(0, 11));
      for (int i = 1; i < lat; i++) begin
         chk({tag, " calc ready"}, 32'(in_ready), 0);
         chk({tag, " calc strobes"}, 32'({wb_reg_write, wb_car_write}), 0);
         tick;
      end
      if (!nop) begin
         exp_addr = rd;
         exp_rd   = res;
         if (carw) exp_car = car;
      end
      chk({tag, " wb busy"}, 32'(busy), 1);
      chk({tag, " wb ready"}, 32'(in_ready), 1);
      chk({tag, " wb reg_write"}, 32'(wb_reg_write), 32'(!nop && rd != 0));
      chk({tag, " wb car_write"}, 32'(wb_car_write), 32'(!nop && carw));
      chk({tag, " wb addr"}, 32'(wb_rd_addr), exp_addr);
      chk({tag, " wb rd_in"}, 32'(wb_rd_in), exp_rd);
      chk({tag, " wb car_in"}, 32'(wb_car_in), exp_car);
      if (go_idle) begin
         tick;
         chk_idle_hold(tag);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " ready"}, 32'(in_ready), 1);
      chk({tag, " busy"}, 32'(busy), 0);
      chk({tag, " strobes"}, 32'({wb_reg_write, wb_car_write}), 0);
      chk({tag, " addr"}, 32'(wb_rd_addr), 0);
      chk({tag, " rd_in"}, 32'(wb_rd_in), 0);
      chk({tag, " car_in"}, 32'(wb_car_in), 0);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      op       = 3'd0;
      rs_val   = 8'd0;
      rt_val   = 8'd0;
      rd_addr  = 4'd0;
      tick;
      tick;
      chk_reset_state("reset");
      reset = 1'b0;
      tick;
      chk_reset_state("post reset");

      run_op(0, 'hF0, 'h20, 3, 1'b1, "add");
      run_op(1, 'h05, 'h07, 0, 1'b1, "sub rd0");
      run_op(1, 'h07, 'h05, 9, 1'b1, "sub noborrow");
      run_op(5, 'h81, 'h03, 5, 1'b1, "shl3");
      run_op(6, 'h81, 'hFF, 6, 1'b1, "shr7");
      run_op(5, 'h5A, 'h08, 2, 1'b1, "shl0");
      run_op(7, 'hFF, 'hFF, 4, 1'b1, "mul");
      run_op(2, 'hCC, 'hAA, 11, 1'b1, "and");
      run_op(3, 'hCC, 'hAA, 1, 1'b1, "or");

      for (int k = 0; k < 4; k++)
         run_op(4, $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(1, 11), (k == 3), "xor b2b");

      run_op(4, 'h3C, 'h0F, 7, 1'b0, "chain xor");
      run_op(5, 'h33, 'h02, 8, 1'b1, "chain shl");

      for (int k = 0; k < 60; k++)
         run_op($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 11), 1'($urandom_range(0, 1)), "random");

      // reset during a multiply, in_valid held high to check reset priority
      in_valid = 1'b1;
      op       = 3'd7;
      rs_val   = 8'hFF;
      rt_val   = 8'hFF;
      rd_addr  = 4'd5;
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      tick;
      reset    = 1'b1;
      in_valid = 1'b1;
      op       = 3'd0;
      rd_addr  = 4'd3;
      tick;
      chk_reset_state("mul reset");
      reset    = 1'b0;
      in_valid = 1'b0;
      tick;
      chk_reset_state("mul after reset");
      exp_addr = 0;
      exp_rd   = 0;
      exp_car  = 0;

      // reset in the middle of a long shift
      in_valid = 1'b1;
      op       = 3'd6;
      rs_val   = 8'hF0;
      rt_val   = 8'h07;
      rd_addr  = 4'd2;
      tick;
      in_valid = 1'b0;
      tick;
      chk("shr calc ready", 32'(in_ready), 0);
      reset = 1'b1;
      tick;
      chk_reset_state("shr reset");
      reset = 1'b0;
      tick;
      chk_reset_state("shr after reset");

      run_op(0, 'hFF, 'h01, 10, 1'b1, "add after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
